// File: rtl/link_ingress_arbiter.sv
// link_ingress_arbiter: round-robin merge of NUM_SOURCES valid/ready streams
// into one registered output stream for the message handler.
// Grants are held for bursts of up to MAX_BURST words. Each grant change
// costs one IDLE bubble cycle.
// Optional feature macro: LINK_ARB_PARENT_PRIORITY_EN. When it is defined,
// source 0 (the parent link) has strict priority, can pre-empt other grants,
// and is not limited by MAX_BURST.
module link_ingress_arbiter #(
  parameter int NUM_SOURCES = 3,
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_BURST   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SOURCES-1:0]            in_valid,
  output logic [NUM_SOURCES-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NUM_SOURCES)-1:0]    grant_id,
  output logic                              busy
);
  localparam int IDW = $clog2(NUM_SOURCES);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt, grant_nxt, pick;
  logic [7:0]     burst_cnt, burst_nxt;
  logic           slot_free, xfer, last_word, preempt, adv_ptr;

  function automatic logic [IDW-1:0] inc_idx(input logic [IDW-1:0] i);
    if (int'(i) == NUM_SOURCES - 1) return '0;
    else return i + IDW'(1);
  endfunction

  assign slot_free = !out_valid || out_ready;
  assign xfer      = |(in_valid & in_ready);
  assign busy      = (|in_valid) || out_valid || (state == HOLD);

`ifdef LINK_ARB_PARENT_PRIORITY_EN
  // Parent bursts are unbounded; a waiting parent cuts other grants short.
  // Ending a parent grant leaves rr_ptr alone so the 1..N-1 rotation is undisturbed.
  assign last_word = (burst_cnt == 8'(MAX_BURST - 1)) && (grant_id != '0);
  assign preempt   = (grant_id != '0) && in_valid[0];
  assign adv_ptr   = (grant_id != '0);
`else
  assign last_word = (burst_cnt == 8'(MAX_BURST - 1));
  assign preempt   = 1'b0;
  assign adv_ptr   = 1'b1;
`endif

  // First valid source at or above rr_ptr, wrapping; lowest distance wins.
  always_comb begin
    pick = rr_ptr;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      if (in_valid[(int'(rr_ptr) + k) % NUM_SOURCES])
        pick = IDW'((int'(rr_ptr) + k) % NUM_SOURCES);
    end
`ifdef LINK_ARB_PARENT_PRIORITY_EN
    if (in_valid[0]) pick = '0;
`endif
  end

  // Only the granted source sees ready, and only when the output slot frees up.
  always_comb begin
    in_ready = '0;
    if (state == HOLD && !reset) in_ready[grant_id] = slot_free;
  end

  // Grant FSM next-state: IDLE picks a source, HOLD counts the burst and releases.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (|in_valid) begin
          state_nxt = HOLD;
          grant_nxt = pick;
          burst_nxt = '0;
        end
      end
      HOLD: begin
        if (xfer) burst_nxt = burst_cnt + 8'd1;
        if (!in_valid[grant_id] || (xfer && last_word) || preempt) begin
          state_nxt = IDLE;
          if (adv_ptr) rr_nxt = inc_idx(grant_id);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Output register: load on transfer, drain when the handler accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/link_ingress_arbiter.md
Name: link_ingress_arbiter

Overview:
- Round-robin arbiter that merges NUM_SOURCES independent 64-bit valid/ready streams into the single 64-bit ingress port of message_handler.
- Typical sources: parent link rx and the grid_1/grid_2 neighbour links.
- Grant is held per source for bursts of up to MAX_BURST words, then rotates.
- Output word is registered, so the handler sees a clean single-stage pipeline.

Parameters:
- NUM_SOURCES, 3, number of input streams (2..8).
- DATA_WIDTH, 64, width of each stream word.
- MAX_BURST, 4, maximum consecutive words accepted from one source per grant (1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_SOURCES*DATA_WIDTH  source words; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_SOURCES  per-source valid.
- in_ready  output  NUM_SOURCES  per-source ready; at most one bit high.
- out_data  output  DATA_WIDTH  registered merged word to message_handler.
- out_valid  output  1  out_data valid.
- out_ready  input  1  handler accepts out_data.
- grant_id  output  $clog2(NUM_SOURCES)  currently/last granted source.
- busy  output  1  high while any in_valid is high, out_valid is high, or state is HOLD; feeds router_busy.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, grant_id=0, busy=0, state=IDLE, rr_ptr=0, burst_cnt=0.
- slot_free = !out_valid || out_ready.
- A transfer occurs in a cycle where in_valid[g] && in_ready[g].
- State IDLE:
  - in_ready all 0.
  - If any in_valid is high, select the first valid index searching upward from rr_ptr with wrap (NUM_SOURCES-1 -> 0).
  - Register it into grant_id, clear burst_cnt to 0, go to HOLD.
  - No transfer is possible in the IDLE cycle.
- State HOLD (grant g = grant_id):
  - in_ready[g] = slot_free, combinational from registered state and out_ready. All other in_ready bits are 0.
  - On transfer: out_data <= word g, out_valid <= 1, burst_cnt <= burst_cnt+1.
  - If the transfer is at burst_cnt == MAX_BURST-1: go to IDLE, rr_ptr <= (g+1) mod NUM_SOURCES.
  - If in_valid[g] is low: go to IDLE, rr_ptr <= (g+1) mod NUM_SOURCES.
  - If in_valid[g] is high and slot_free is low (output stalled): stay in HOLD, hold burst_cnt.
- Output register:
  - out_valid falls when out_ready is high and no new transfer occurs that cycle.
  - out_data holds while out_valid && !out_ready.
- Latency: in_valid rises in cycle N with the arbiter IDLE -> in_ready in N+1 -> out_valid in N+2.
- Throughput: 1 word/cycle within a burst. One bubble cycle per grant change (the IDLE cycle).
- Simultaneous requests: resolved purely by rr_ptr; no source is starved. Worst-case wait is (NUM_SOURCES-1)*(MAX_BURST+1) cycles plus output stalls.
- Protocol:
  - Sources hold valid and data stable until accepted.
  - Dropping valid while ready is low only forfeits the grant; no data is lost.
- Reset asserted mid-burst: the word in the output register is discarded, all state returns to reset values the next cycle, and no in_ready is asserted during reset.
- Order within one source is preserved. There is no ordering guarantee across sources.

Optional Feature:
- Macro LINK_ARB_PARENT_PRIORITY_EN.
- Defined:
  - Source 0 (parent link) has strict priority. In IDLE, in_valid[0] selects source 0 regardless of rr_ptr.
  - In HOLD on another source, a high in_valid[0] ends that grant after the current cycle's transfer (early IDLE return). rr_ptr still advances past the pre-empted source.
  - Source 0 bursts are not limited by MAX_BURST.
  - Round-robin among sources 1..NUM_SOURCES-1 is unchanged.
- Undefined: plain round-robin exactly as in Behaviour; source 0 is treated like any other source.

Test Plan:
- Single source: NUM_SOURCES=3, MAX_BURST=4, out_ready=1, source 1 sends words 0xA0..0xA5 back-to-back -> output 0xA0..0xA3 consecutively, one bubble cycle, then 0xA4, 0xA5. grant_id=1 throughout, rr_ptr ends at 2.
- Contention: all three sources continuously valid, out_ready=1 -> grant order 0,1,2,0,... with 4 words each and one bubble between bursts. in_ready is never high on two sources at once.
- Backpressure: out_ready=0 for 5 cycles mid-burst from source 2 -> out_data holds its value, exactly one word is buffered, in_ready[2]=0. After release the sequence resumes with no loss or duplication and burst_cnt is unchanged.
- Grant release: source 0 sends 2 words then drops valid while source 1 is waiting -> return to IDLE, source 1 is granted in the next cycle, rr_ptr=1.
- Reset mid-burst: assert reset while out_valid=1 and state=HOLD -> the next cycle shows out_valid=0, in_ready=0, grant_id=0, busy=0. The first arbitration after reset starts from source 0.
- With LINK_ARB_PARENT_PRIORITY_EN: source 1 is in a burst and source 0 raises valid -> after the current transfer, source 0 is granted following the IDLE cycle. Source 0 sends 6 words uninterrupted, then source 2 is granted.
